// File: rtl/btn_pkg.sv
// Shared definitions for the multi-channel button conditioner.
// Contains:
//   - the per-channel FSM state type, with a 2-bit encoding;
//   - the default parameter values;
//   - a counter-width helper, so that every counter is just wide enough for its limit.
package btn_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPressed = 2'd1,
    StHeld    = 2'd2
  } btn_state_e;

  localparam int unsigned DefNCh           = 5;
  localparam int unsigned DefSampleDiv     = 100000;
  localparam int unsigned DefStableSamples = 4;
  localparam int unsigned DefLongSamples   = 1000;
  localparam int unsigned DefRepeatSamples = 100;

  // Bits needed to count 0..limit-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit <= 1) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchroniser, tick-sampled integrating debounce,
// press/release/long/repeat FSM, all outputs registered.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   tick           one-cycle sample enable shared by all channels
//   i_btn          raw asynchronous button input
//   i_repeat_en    auto-repeat enable while held
//   o_level        debounced level
//   o_press        1-clk pulse on debounced rise
//   o_release      1-clk pulse on debounced fall
//   o_long         1-clk pulse when the hold reaches LONG_SAMPLES ticks
//   o_repeat       1-clk pulse every REPEAT_SAMPLES ticks after o_long
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = DefStableSamples,
  parameter int unsigned LONG_SAMPLES   = DefLongSamples,
  parameter int unsigned REPEAT_SAMPLES = DefRepeatSamples
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic i_btn,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int unsigned StabW = cnt_width(STABLE_SAMPLES);
  localparam int unsigned HoldW = cnt_width(LONG_SAMPLES);
  localparam int unsigned RepW  = cnt_width(REPEAT_SAMPLES);
  localparam logic [StabW-1:0] StabMax = StabW'(STABLE_SAMPLES - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_SAMPLES - 1);
  localparam logic [RepW-1:0]  RepMax  = RepW'(REPEAT_SAMPLES - 1);

  logic             sync1_q, sync1_d, sync_q, sync_d;
  logic             level_q, level_d;
  logic [StabW-1:0] stab_q, stab_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [RepW-1:0]  rep_q, rep_d;
  btn_state_e       state_q, state_d;
  logic             press_q, press_d, release_q, release_d;
  logic             long_q, long_d, repeat_q, repeat_d;

  always_comb begin
    sync1_d   = i_btn;
    sync_d    = sync1_q;
    level_d   = level_q;
    stab_d    = stab_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    if (tick) begin
      // Integrator: any agreeing sample restarts qualification.
      if (sync_q == level_q) begin
        stab_d = '0;
      end else if (stab_q == StabMax) begin
        level_d = sync_q;
        stab_d  = '0;
      end else begin
        stab_d = stab_q + 1'b1;
      end

      // Edges are taken from the new level, so a fall on the long/repeat tick wins.
      if (level_d && !level_q) begin
        press_d = 1'b1;
        state_d = StPressed;
        hold_d  = '0;
        rep_d   = '0;
      end else if (!level_d && level_q) begin
        release_d = 1'b1;
        state_d   = StIdle;
        hold_d    = '0;
        rep_d     = '0;
      end else if (level_q) begin
        case (state_q)
          StPressed: begin
            if (hold_q == HoldMax) begin
              long_d  = 1'b1;
              state_d = StHeld;
              rep_d   = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
          StHeld: begin
            // Hold counter is frozen here; only the repeat counter runs.
            if (!i_repeat_en) begin
              rep_d = '0;
            end else if (rep_q == RepMax) begin
              repeat_d = 1'b1;
              rep_d    = '0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync_q    <= 1'b0;
      level_q   <= 1'b0;
      stab_q    <= '0;
      hold_q    <= '0;
      rep_q     <= '0;
      state_q   <= StIdle;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync_q    <= sync_d;
      level_q   <= level_d;
      stab_q    <= stab_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;

endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel button conditioner: one shared sample-tick prescaler feeding N_CH
// independent btn_channel instances. No derived clocks.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   i_btn          raw asynchronous button inputs, active-high
//   i_repeat_en    per-channel auto-repeat enable
//   o_level        debounced levels
//   o_press        1-clk pulses on debounced rising edges
//   o_release      1-clk pulses on debounced falling edges
//   o_long         1-clk pulses when a hold reaches LONG_SAMPLES ticks
//   o_repeat       1-clk pulses every REPEAT_SAMPLES ticks after o_long
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int unsigned N_CH           = DefNCh,
  parameter int unsigned SAMPLE_DIV     = DefSampleDiv,
  parameter int unsigned STABLE_SAMPLES = DefStableSamples,
  parameter int unsigned LONG_SAMPLES   = DefLongSamples,
  parameter int unsigned REPEAT_SAMPLES = DefRepeatSamples
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_btn,
  input  logic [N_CH-1:0] i_repeat_en,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_long,
  output logic [N_CH-1:0] o_repeat
);

  localparam int unsigned DivW = cnt_width(SAMPLE_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(SAMPLE_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic            tick;

  // Tick is decoded from the terminal count, so it lasts exactly one clk.
  always_comb begin
    tick  = (div_q == DivMax);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_channel #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .LONG_SAMPLES  (LONG_SAMPLES),
      .REPEAT_SAMPLES(REPEAT_SAMPLES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .i_btn      (i_btn[g]),
      .i_repeat_en(i_repeat_en[g]),
      .o_level    (o_level[g]),
      .o_press    (o_press[g]),
      .o_release  (o_release[g]),
      .o_long     (o_long[g]),
      .o_repeat   (o_repeat[g])
    );
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Scoreboard bench for btn_debounce_multi (N_CH=2, SAMPLE_DIV=4, STABLE=3, LONG=8, REPEAT=4).
// Stimulus pushes expected pulse events (kind, channel, timing window) into a queue; the
// monitor pops one entry per observed pulse and checks kind, channel and timing. Timing is
// either an absolute cycle window or an exact gap from an earlier event on the same channel.
module tb_btn_debounce_multi;

  localparam int KPress = 0, KRelease = 1, KLong = 2, KRepeat = 3, KAbs = -1;

  logic       clk, rst;
  logic [1:0] i_btn, i_repeat_en;
  logic [1:0] o_level, o_press, o_release, o_long, o_repeat;

  btn_debounce_multi #(
    .N_CH          (2),
    .SAMPLE_DIV    (4),
    .STABLE_SAMPLES(3),
    .LONG_SAMPLES  (8),
    .REPEAT_SAMPLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_btn      (i_btn),
    .i_repeat_en(i_repeat_en),
    .o_level    (o_level),
    .o_press    (o_press),
    .o_release  (o_release),
    .o_long     (o_long),
    .o_repeat   (o_repeat)
  );

  typedef struct {
    int kind;
    int ch;
    int ref_kind;
    int lo;
    int hi;
  } exp_t;

  exp_t  sb[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_fail = 0;
  int    last_t[2][4];
  logic  mon_en = 1'b0;
  string kname[4] = '{"press", "release", "long", "repeat"};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic push(input int kind, input int ch, input int ref_kind, input int lo,
                      input int hi);
    exp_t e;
    e.kind = kind; e.ch = ch; e.ref_kind = ref_kind; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  function automatic logic pulse_bit(input int k, input int ch);
    case (k)
      0:       return o_press[ch];
      1:       return o_release[ch];
      2:       return o_long[ch];
      default: return o_repeat[ch];
    endcase
  endfunction

  // Monitor: every observed pulse consumes exactly one expectation.
  always @(negedge clk) begin
    exp_t e;
    int   t;
    if (mon_en) begin
      for (int ch = 0; ch < 2; ch++) begin
        for (int k = 0; k < 4; k++) begin
          if (pulse_bit(k, ch)) begin
            if (sb.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL unexpected %s ch%0d at cycle %0d", kname[k], ch, cyc);
            end else begin
              e = sb.pop_front();
              check($sformatf("event id (expected %s ch%0d, 10*kind+ch)", kname[e.kind], e.ch),
                    10 * k + ch, 10 * e.kind + e.ch, 10 * e.kind + e.ch);
              t = (e.ref_kind == KAbs) ? cyc : cyc - last_t[ch][e.ref_kind];
              check($sformatf("%s ch%0d timing", kname[k], ch), t, e.lo, e.hi);
              if (k == KPress)   check($sformatf("press ch%0d level", ch), int'(o_level[ch]), 1, 1);
              if (k == KRelease) check($sformatf("release ch%0d level", ch), int'(o_level[ch]), 0, 0);
            end
            last_t[ch][k] = cyc;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_press(input int ch, output int p);
    p = -1;
    for (int i = 0; i < 40 && p < 0; i++) begin
      step(1);
      if (o_press[ch]) p = cyc;
    end
    if (p < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL press wait ch%0d: no pulse within 40 cycles", ch);
      p = cyc;
    end
  endtask

  int c, p, r;

  initial begin
    for (int a = 0; a < 2; a++) for (int b = 0; b < 4; b++) last_t[a][b] = 0;
    rst = 1'b1;
    i_btn = 2'b11;
    i_repeat_en = 2'b00;

    // 1. Reset with both buttons held, then both re-qualify together.
    for (int i = 0; i < 3; i++) begin
      step(1);
      mon_en = 1'b1;
      check("outputs during reset", {o_level, o_press, o_release, o_long, o_repeat}, 0, 0);
    end
    rst = 1'b0;
    r = cyc;
    push(KPress, 0, KAbs, r + 1, r + 14);
    push(KPress, 1, KAbs, r + 1, r + 14);
    step(20);
    check("level after reset qualify", int'(o_level), 3, 3);
    i_btn = 2'b00;
    c = cyc;
    push(KRelease, 0, KAbs, c + 11, c + 14);
    push(KRelease, 1, KAbs, c + 11, c + 14);
    step(20);

    // 2. Bouncing press then bouncing release on channel 0.
    for (int i = 0; i < 20; i++) begin
      i_btn[0] = ~i_btn[0];
      step(3);
    end
    i_btn[0] = 1'b1;
    c = cyc;
    push(KPress, 0, KAbs, c + 1, c + 14);
    wait_press(0, p);
    for (int i = 0; i < 4; i++) begin
      i_btn[0] = ~i_btn[0];
      step(3);
    end
    i_btn[0] = 1'b0;
    c = cyc;
    push(KRelease, 0, KAbs, c + 1, c + 14);
    step(20);
    check("level after bounce release", int'(o_level), 0, 0);

    // 3. Two-tick glitch on channel 1 is rejected.
    i_btn[1] = 1'b1;
    step(8);
    i_btn[1] = 1'b0;
    step(20);
    check("glitch level ch1", int'(o_level[1]), 0, 0);

    // 4a. Long press with auto-repeat.
    i_repeat_en[0] = 1'b1;
    i_btn[0] = 1'b1;
    c = cyc;
    push(KPress, 0, KAbs, c + 11, c + 14);
    push(KLong, 0, KPress, 32, 32);
    push(KRepeat, 0, KLong, 16, 16);
    push(KRepeat, 0, KRepeat, 16, 16);
    push(KRepeat, 0, KRepeat, 16, 16);
    wait_press(0, p);
    step(80);
    i_btn[0] = 1'b0;
    c = cyc;
    push(KRelease, 0, KAbs, c + 11, c + 14);
    step(20);

    // 4b. Long press without auto-repeat.
    i_repeat_en[0] = 1'b0;
    i_btn[0] = 1'b1;
    c = cyc;
    push(KPress, 0, KAbs, c + 11, c + 14);
    push(KLong, 0, KPress, 32, 32);
    wait_press(0, p);
    step(80);
    i_btn[0] = 1'b0;
    c = cyc;
    push(KRelease, 0, KAbs, c + 11, c + 14);
    step(20);

    // 5. Level falls on the 8th tick after the press: release wins, no long.
    i_btn[0] = 1'b1;
    c = cyc;
    push(KPress, 0, KAbs, c + 11, c + 14);
    push(KRelease, 0, KPress, 32, 32);
    wait_press(0, p);
    step(20);
    i_btn[0] = 1'b0;
    step(30);

    // 6. Reset while HELD: silent clear, then a fresh press and long.
    i_btn[0] = 1'b1;
    c = cyc;
    push(KPress, 0, KAbs, c + 11, c + 14);
    push(KLong, 0, KPress, 32, 32);
    wait_press(0, p);
    step(36);
    rst = 1'b1;
    step(1);
    check("outputs after mid-hold reset", {o_level, o_press, o_release, o_long, o_repeat}, 0, 0);
    rst = 1'b0;
    r = cyc;
    push(KPress, 0, KAbs, r + 1, r + 14);
    push(KLong, 0, KPress, 32, 32);
    wait_press(0, p);
    step(40);
    i_btn[0] = 1'b0;
    c = cyc;
    push(KRelease, 0, KAbs, c + 11, c + 14);
    step(30);

    check("scoreboard entries left", sb.size(), 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
